mem_arbiter: RTL and testbench

//  Shares one multi-cycle backing-memory port between the MIPS instruction-fetch port and its data port.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the MIPS fetch and data ports onto one multi-cycle backing-memory port.
// Data wins by default; after MAXD back-to-back data grants a waiting fetch is served next.
module mem_arbiter #(
    parameter int N       = 64,
    parameter int MAXD    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ireq,
    input  logic [31:0]  iadr,
    output logic         idone,
    output logic [31:0]  irdata,
    input  logic         dreq,
    input  logic [1:0]   dwe,
    input  logic         dword,
    input  logic [N-1:0] dadr,
    input  logic [N-1:0] dwdata,
    output logic         ddone,
    output logic [N-1:0] drdata,
    output logic         mem_req,
    output logic [1:0]   mem_we,
    output logic         mem_dword,
    output logic [N-1:0] mem_adr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_rdata,
    output logic         ready,
    output logic         err
);
    localparam int DW = $clog2(MAXD + 1);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} state_t;

    state_t        state;
    logic [DW-1:0] dcnt;
    logic [7:0]    tcnt;
    logic          dgrant;
    logic          timeout_hit;
    logic [N-1:0]  rdata_sized;

    always_comb begin
        dgrant      = dreq && (!ireq || (dcnt < DW'(MAXD)));
        timeout_hit = (tcnt == 8'(TIMEOUT - 1));
        rdata_sized = mem_dword ? mem_rdata : {{(N-32){1'b0}}, mem_rdata[31:0]};
        ready       = ~((ireq & ~idone) | (dreq & ~ddone));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idone     <= 1'b0;
            ddone     <= 1'b0;
            irdata    <= '0;
            drdata    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= '0;
            mem_dword <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            dcnt      <= '0;
            tcnt      <= '0;
        end else begin
            idone <= 1'b0;
            ddone <= 1'b0;
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (dgrant) begin
                        state     <= DBUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= dwe;
                        // word writes are 32-bit; dword writes are always 64-bit
                        mem_dword <= dwe[1] | ((dwe == 2'b00) & dword);
                        mem_adr   <= dadr;
                        mem_wdata <= dwdata;
                        dcnt      <= ireq ? dcnt + 1'b1 : '0;
                    end else if (ireq) begin
                        state     <= IBUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= 2'b00;
                        mem_dword <= 1'b0;
                        mem_adr   <= {{(N-32){1'b0}}, iadr};
                        mem_wdata <= dwdata;
                        dcnt      <= '0;
                    end else begin
                        dcnt <= '0;
                    end
                end
                IBUSY, DBUSY: begin
                    if (mem_ack || timeout_hit) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        err     <= err | ~mem_ack;
                        // an expired access returns zero rather than stale bus data
                        if (state == IBUSY) begin
                            idone  <= 1'b1;
                            irdata <= mem_ack ? mem_rdata[31:0] : '0;
                        end else begin
                            ddone  <= 1'b1;
                            drdata <= mem_ack ? rdata_sized : '0;
                        end
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a vector table of single accesses, directed multi-cycle sequences,
// and a random request mix checked against a transaction-level arbitration model.
module tb_mem_arbiter;
    localparam int N    = 64;
    localparam int MAXD = 4;
    localparam int TMO  = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         ireq;
    logic [31:0]  iadr;
    logic         idone;
    logic [31:0]  irdata;
    logic         dreq;
    logic [1:0]   dwe;
    logic         dword;
    logic [N-1:0] dadr;
    logic [N-1:0] dwdata;
    logic         ddone;
    logic [N-1:0] drdata;
    logic         mem_req;
    logic [1:0]   mem_we;
    logic         mem_dword;
    logic [N-1:0] mem_adr;
    logic [N-1:0] mem_wdata;
    logic         mem_ack;
    logic [N-1:0] mem_rdata;
    logic         ready;
    logic         err;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.N(N), .MAXD(MAXD), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iadr(iadr), .idone(idone), .irdata(irdata),
        .dreq(dreq), .dwe(dwe), .dword(dword), .dadr(dadr), .dwdata(dwdata),
        .ddone(ddone), .drdata(drdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_dword(mem_dword), .mem_adr(mem_adr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ready(ready), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        isd;
        logic [1:0]  we;
        logic        dw;
        logic [63:0] adr;
        logic [63:0] wdata;
        int          delay;
        logic [63:0] rdata;
        logic [63:0] exp_adr;
        logic [1:0]  exp_we;
        logic        exp_dword;
        logic        chk_data;
        logic [63:0] exp_data;
    } vec_t;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_i();
        ireq = 1'b1;
        iadr = $urandom;
    endtask

    task automatic new_d();
        dreq   = 1'b1;
        dwe    = 2'($urandom_range(0, 3));
        dword  = 1'($urandom_range(0, 1));
        dadr   = {$urandom, $urandom};
        dwdata = {$urandom, $urandom};
    endtask

    // Starts in an IDLE cycle with no requests; ends in the IDLE cycle after done.
    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("vec%0d", idx);
        mem_ack = 1'b0;
        if (v.isd) begin
            dreq = 1'b1; dwe = v.we; dword = v.dw; dadr = v.adr; dwdata = v.wdata;
        end else begin
            ireq = 1'b1; iadr = v.adr[31:0];
        end
        tick();
        chk1({p, ".mem_req"}, mem_req, 1'b1);
        chk64({p, ".mem_adr"}, mem_adr, v.exp_adr);
        chk64({p, ".mem_we"}, 64'(mem_we), 64'(v.exp_we));
        if (!(v.isd && v.we == 2'b01)) chk1({p, ".mem_dword"}, mem_dword, v.exp_dword);
        if (v.isd && v.we != 2'b00) chk64({p, ".mem_wdata"}, mem_wdata, v.wdata);
        chk1({p, ".ready_busy"}, ready, 1'b0);
        for (int c = 0; c < v.delay; c++) begin
            tick();
            chk1({p, ".mem_req_hold"}, mem_req, 1'b1);
        end
        mem_ack = 1'b1;
        mem_rdata = v.rdata;
        tick();
        mem_ack = 1'b0;
        chk1({p, ".idone"}, idone, !v.isd);
        chk1({p, ".ddone"}, ddone, v.isd);
        chk1({p, ".mem_req_done"}, mem_req, 1'b0);
        chk1({p, ".ready_done"}, ready, 1'b1);
        if (v.chk_data) begin
            if (v.isd) chk64({p, ".drdata"}, drdata, v.exp_data);
            else chk64({p, ".irdata"}, {32'b0, irdata}, v.exp_data);
        end
        ireq = 1'b0;
        dreq = 1'b0;
        tick();
        chk1({p, ".idone_off"}, idone, 1'b0);
        chk1({p, ".ddone_off"}, ddone, 1'b0);
    endtask

    task automatic run_vectors();
        vec_t vecs[7];
        vecs[0] = '{1'b0, 2'b00, 1'b0, 64'h40, 64'h0, 0, 64'h2008_0005,
                    64'h40, 2'b00, 1'b0, 1'b1, 64'h2008_0005};
        vecs[1] = '{1'b0, 2'b00, 1'b0, 64'h1234_5678_FFFF_FFFC, 64'h0, 2, 64'hDEAD_BEEF_CAFE_F00D,
                    64'h0000_0000_FFFF_FFFC, 2'b00, 1'b0, 1'b1, 64'h0000_0000_CAFE_F00D};
        vecs[2] = '{1'b1, 2'b00, 1'b0, 64'h1000, 64'h0, 0, 64'hFFFF_FFFF_1234_5678,
                    64'h1000, 2'b00, 1'b0, 1'b1, 64'h0000_0000_1234_5678};
        vecs[3] = '{1'b1, 2'b00, 1'b1, 64'h8000_0000_0000_0008, 64'h0, 1, 64'hFFFF_FFFF_1234_5678,
                    64'h8000_0000_0000_0008, 2'b00, 1'b1, 1'b1, 64'hFFFF_FFFF_1234_5678};
        vecs[4] = '{1'b1, 2'b01, 1'b1, 64'h80, 64'h1111_2222_3333_4444, 0, 64'h5,
                    64'h80, 2'b01, 1'b0, 1'b0, 64'h0};
        vecs[5] = '{1'b1, 2'b10, 1'b0, 64'h88, 64'hAAAA_5555_AAAA_5555, 3, 64'h6,
                    64'h88, 2'b10, 1'b1, 1'b0, 64'h0};
        vecs[6] = '{1'b1, 2'b11, 1'b0, 64'h90, 64'h0123_4567_89AB_CDEF, 0, 64'h7,
                    64'h90, 2'b11, 1'b1, 1'b0, 64'h0};
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
    endtask

    task automatic test_simul();
        ireq = 1'b1; iadr = 32'h44;
        dreq = 1'b1; dwe = 2'b01; dword = 1'b0; dadr = 64'h80; dwdata = 64'h99;
        tick();
        chk64("simul.first_adr", mem_adr, 64'h80);
        chk64("simul.first_we", 64'(mem_we), 64'h1);
        mem_ack = 1'b1; mem_rdata = 64'h0;
        tick();
        mem_ack = 1'b0;
        chk1("simul.ddone", ddone, 1'b1);
        chk1("simul.idone_early", idone, 1'b0);
        chk1("simul.ready_iwait", ready, 1'b0);
        dreq = 1'b0;
        tick();
        tick();
        chk64("simul.second_adr", mem_adr, 64'h44);
        chk64("simul.second_we", 64'(mem_we), 64'h0);
        mem_ack = 1'b1; mem_rdata = 64'hFFFF_0000_0BAD_F00D;
        tick();
        mem_ack = 1'b0;
        chk1("simul.idone", idone, 1'b1);
        chk64("simul.irdata", {32'b0, irdata}, 64'h0BAD_F00D);
        ireq = 1'b0;
        tick();
    endtask

    task automatic test_starve();
        logic isd;
        ireq = 1'b1; iadr = 32'h100;
        dreq = 1'b1; dwe = 2'b00; dword = 1'b1; dadr = 64'h200;
        for (int g = 0; g < 6; g++) begin
            isd = (g != 4);
            tick();
            chk64($sformatf("starve.grant%0d", g), mem_adr, isd ? 64'h200 : 64'h100);
            mem_ack = 1'b1; mem_rdata = 64'(g + 1);
            tick();
            mem_ack = 1'b0;
            chk1($sformatf("starve.ddone%0d", g), ddone, isd);
            chk1($sformatf("starve.idone%0d", g), idone, !isd);
            tick();
        end
        ireq = 1'b0;
        dreq = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        chk1("tmo.err_before", err, 1'b0);
        mem_ack = 1'b0;
        dreq = 1'b1; dwe = 2'b00; dword = 1'b1; dadr = 64'h300;
        for (int c = 1; c <= TMO; c++) begin
            tick();
            chk1($sformatf("tmo.req%0d", c), mem_req, 1'b1);
            chk1($sformatf("tmo.ddone_early%0d", c), ddone, 1'b0);
        end
        tick();
        chk1("tmo.req_off", mem_req, 1'b0);
        chk1("tmo.ddone", ddone, 1'b1);
        chk64("tmo.drdata_zero", drdata, 64'h0);
        chk1("tmo.err", err, 1'b1);
        dreq = 1'b0;
        tick();
        ireq = 1'b1; iadr = 32'h10;
        tick();
        mem_ack = 1'b1; mem_rdata = 64'h77;
        tick();
        mem_ack = 1'b0;
        chk1("tmo.after_idone", idone, 1'b1);
        chk1("tmo.err_sticky", err, 1'b1);
        ireq = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        dreq = 1'b1; dwe = 2'b00; dword = 1'b1; dadr = 64'h400;
        mem_ack = 1'b0;
        tick();
        chk1("rst.busy", mem_req, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        chk1("rst.req_off", mem_req, 1'b0);
        chk1("rst.ddone", ddone, 1'b0);
        chk1("rst.err", err, 1'b0);
        reset = 1'b0;
        dreq = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk1("rst.no_ddone", ddone, 1'b0);
            chk1("rst.idle_req", mem_req, 1'b0);
        end
        dreq = 1'b1; dadr = 64'h500;
        tick();
        chk1("rst.new_req", mem_req, 1'b1);
        chk64("rst.new_adr", mem_adr, 64'h500);
        mem_ack = 1'b1; mem_rdata = 64'h5;
        tick();
        mem_ack = 1'b0;
        chk1("rst.new_ddone", ddone, 1'b1);
        dreq = 1'b0;
        tick();
    endtask

    // Model: D wins unless fetch is waiting and MAXD data grants have already run back-to-back.
    task automatic random_test(input int count);
        int          dstreak;
        int          d;
        logic        gd;
        logic        e_dword;
        logic        chk_dw;
        logic [1:0]  e_we;
        logic [63:0] e_adr;
        logic [63:0] e_wdata;
        logic [63:0] rd;
        dstreak = 0;
        for (int n = 0; n < count; n++) begin
            if (!ireq && !dreq) begin
                dstreak = 0;
                tick();
                chk1("rnd.idle_req", mem_req, 1'b0);
                if ($urandom_range(0, 1) == 1) new_i(); else new_d();
            end
            gd = dreq && (!ireq || dstreak < MAXD);
            dstreak = (gd && ireq) ? dstreak + 1 : 0;
            if (gd) begin
                e_adr = dadr; e_we = dwe; e_wdata = dwdata;
                e_dword = (dwe == 2'b00) ? dword : 1'b1;
                chk_dw = (dwe != 2'b01);
            end else begin
                e_adr = {32'b0, iadr}; e_we = 2'b00; e_wdata = 64'h0;
                e_dword = 1'b0; chk_dw = 1'b1;
            end
            mem_ack = 1'($urandom_range(0, 1));
            mem_rdata = {$urandom, $urandom};
            tick();
            mem_ack = 1'b0;
            chk1("rnd.req", mem_req, 1'b1);
            chk64("rnd.adr", mem_adr, e_adr);
            chk64("rnd.we", 64'(mem_we), 64'(e_we));
            if (chk_dw) chk1("rnd.dword", mem_dword, e_dword);
            if (gd && e_we != 2'b00) chk64("rnd.wdata", mem_wdata, e_wdata);
            if ($urandom_range(0, 7) == 0) begin
                if (gd) dreq = 1'b0; else ireq = 1'b0;
            end
            if (gd && !ireq && $urandom_range(0, 3) == 0) new_i();
            else if (!gd && !dreq && $urandom_range(0, 3) == 0) new_d();
            d = $urandom_range(0, 3);
            for (int c = 0; c < d; c++) begin
                tick();
                chk1("rnd.req_hold", mem_req, 1'b1);
                chk64("rnd.adr_hold", mem_adr, e_adr);
            end
            rd = {$urandom, $urandom};
            mem_ack = 1'b1;
            mem_rdata = rd;
            tick();
            mem_ack = 1'($urandom_range(0, 1));
            mem_rdata = {$urandom, $urandom};
            chk1("rnd.idone", idone, !gd);
            chk1("rnd.ddone", ddone, gd);
            chk1("rnd.req_done", mem_req, 1'b0);
            chk1("rnd.ready", ready, !((ireq && gd) || (dreq && !gd)));
            if (!gd) chk64("rnd.irdata", {32'b0, irdata}, {32'b0, rd[31:0]});
            else if (e_we == 2'b00) chk64("rnd.drdata", drdata, e_dword ? rd : {32'b0, rd[31:0]});
            if (gd) begin
                if ($urandom_range(0, 2) == 0) dreq = 1'b0; else new_d();
            end else begin
                if ($urandom_range(0, 2) == 0) ireq = 1'b0; else new_i();
            end
            tick();
            chk1("rnd.idone_off", idone, 1'b0);
            chk1("rnd.ddone_off", ddone, 1'b0);
            chk1("rnd.req_idle", mem_req, 1'b0);
        end
        ireq = 1'b0;
        dreq = 1'b0;
        mem_ack = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ireq = 1'b0; iadr = '0; dreq = 1'b0; dwe = '0; dword = 1'b0;
        dadr = '0; dwdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk1("reset.idone", idone, 1'b0);
        chk1("reset.ddone", ddone, 1'b0);
        chk1("reset.mem_req", mem_req, 1'b0);
        chk1("reset.err", err, 1'b0);
        chk64("reset.irdata", {32'b0, irdata}, 64'h0);
        chk64("reset.drdata", drdata, 64'h0);
        chk64("reset.mem_adr", mem_adr, 64'h0);
        chk64("reset.mem_wdata", mem_wdata, 64'h0);
        chk64("reset.mem_we", 64'(mem_we), 64'h0);
        chk1("reset.mem_dword", mem_dword, 1'b0);
        chk1("reset.ready", ready, 1'b1);
        reset = 1'b0;
        tick();
        run_vectors();
        test_simul();
        test_starve();
        test_timeout();
        test_reset();
        random_test(300);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
